// File: rtl/fsm_pkg.sv
// Shared definitions for the table-driven Moore FSM.
//   - Default widths and reset constants.
//   - Entry layout helpers. An entry is {valid, next[STATE_W], eout[OUT_W]}.
//   - Table address packing: {in_sym, state}.
package fsm_pkg;

    localparam int STATE_W_DEF = 3;
    localparam int IN_W_DEF    = 1;
    localparam int OUT_W_DEF   = 3;

    localparam logic [2:0] RESET_STATE_DEF = 3'd2;
    localparam logic [2:0] RESET_OUT_DEF   = 3'd0;

    // Entry field offsets (LSB positions) within {valid, next, eout).
    localparam int EOUT_LSB = 0;

    function automatic int next_lsb(input int out_w);
        return out_w;
    endfunction

    function automatic int valid_bit(input int state_w, input int out_w);
        return state_w + out_w;
    endfunction

    function automatic int entry_w(input int state_w, input int out_w);
        return 1 + state_w + out_w;
    endfunction

    // Table index: input symbol in the MSBs, current state in the LSBs.
    // Callers cast the result down to STATE_W+IN_W bits.
    function automatic logic [31:0] pack_addr(input int state_w,
                                              input logic [31:0] sym,
                                              input logic [31:0] st);
        return (sym << state_w) | st;
    endfunction

endpackage

// File: rtl/table_fsm_if.sv
// Bus bundle for table_fsm.
//   Step control : en, in_sym      (in_sym is only looked at when en=1)
//   Program port : prog_we, prog_addr, prog_next, prog_out
//   Status       : err_clr (in), state, out, err (out)
// There is no valid/ready handshake: en and prog_we are single-cycle
// strobes that are always accepted on the rising edge they are seen at;
// the block never stalls the driver.
interface table_fsm_if #(
    parameter int STATE_W = 3,
    parameter int IN_W    = 1,
    parameter int OUT_W   = 3
);
    logic                    en;
    logic [IN_W-1:0]         in_sym;
    logic                    prog_we;
    logic [STATE_W+IN_W-1:0] prog_addr;
    logic [STATE_W-1:0]      prog_next;
    logic [OUT_W-1:0]        prog_out;
    logic                    err_clr;
    logic [STATE_W-1:0]      state;
    logic [OUT_W-1:0]        out;
    logic                    err;

    modport master (
        output en, in_sym, prog_we, prog_addr, prog_next, prog_out, err_clr,
        input  state, out, err
    );

    modport slave (
        input  en, in_sym, prog_we, prog_addr, prog_next, prog_out, err_clr,
        output state, out, err
    );
endinterface

// File: rtl/fsm_table.sv
// Transition table for table_fsm: 2^(STATE_W+IN_W) entries held in flops.
//   clk, reset        : clock, async active-low reset (clears valid bits only)
//   we, waddr,        : synchronous write of one entry, marks it valid
//   wnext, wout
//   raddr             : combinational read address
//   rvalid, rnext,    : read entry fields; a same-edge write is not visible
//   rout                until the following cycle (read-before-write)
module fsm_table
    import fsm_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF,
    parameter int IN_W    = IN_W_DEF,
    parameter int OUT_W   = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [STATE_W+IN_W-1:0] waddr,
    input  logic [STATE_W-1:0]      wnext,
    input  logic [OUT_W-1:0]        wout,
    input  logic [STATE_W+IN_W-1:0] raddr,
    output logic                    rvalid,
    output logic [STATE_W-1:0]      rnext,
    output logic [OUT_W-1:0]        rout
);
    localparam int ADDR_W  = STATE_W + IN_W;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int ENTRY_W = entry_w(STATE_W, OUT_W);
    localparam int DATA_W  = ENTRY_W - 1;
    localparam int NEXT_LO = next_lsb(OUT_W);
    localparam int VALID_B = valid_bit(STATE_W, OUT_W);

    logic [DEPTH-1:0]  valid_q;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ENTRY_W-1:0] rd_entry;

    // Valid bits reset so a fresh (or re-reset) table has no usable entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[waddr] <= 1'b1;
        end
    end

    // Payload fields are left unreset; they mean nothing while invalid.
    always_ff @(posedge clk) begin
        if (we) begin
            data_q[waddr] <= {wnext, wout};
        end
    end

    assign rd_entry = {valid_q[raddr], data_q[raddr]};
    assign rvalid   = rd_entry[VALID_B];
    assign rnext    = rd_entry[NEXT_LO +: STATE_W];
    assign rout     = rd_entry[EOUT_LSB +: OUT_W];

endmodule

// File: rtl/table_fsm.sv
// Runtime-programmable, table-driven Moore FSM.
//   clk   : rising-edge clock
//   reset : async active-low; state=RESET_STATE, out=RESET_OUT, err=0,
//           all table entries invalidated
//   bus   : table_fsm_if.slave (step control, program port, status)
// Each enabled step looks up entry {in_sym, state}. A valid entry moves
// to its next state/output; an invalid one falls back to the reset
// state/output and raises the sticky err flag.
module table_fsm
    import fsm_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF,
    parameter int IN_W    = IN_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter logic [STATE_W-1:0] RESET_STATE = STATE_W'(RESET_STATE_DEF),
    parameter logic [OUT_W-1:0]   RESET_OUT   = OUT_W'(RESET_OUT_DEF)
) (
    input  logic        clk,
    input  logic        reset,
    table_fsm_if.slave  bus
);
    localparam int ADDR_W = STATE_W + IN_W;

    logic [STATE_W-1:0] state_q;
    logic [OUT_W-1:0]   out_q;
    logic               err_q;

    logic [ADDR_W-1:0]  rd_addr;
    logic               t_valid;
    logic [STATE_W-1:0] t_next;
    logic [OUT_W-1:0]   t_out;

    assign rd_addr = ADDR_W'(pack_addr(STATE_W, 32'(bus.in_sym), 32'(state_q)));

    fsm_table #(
        .STATE_W (STATE_W),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W)
    ) u_table (
        .clk    (clk),
        .reset  (reset),
        .we     (bus.prog_we),
        .waddr  (bus.prog_addr),
        .wnext  (bus.prog_next),
        .wout   (bus.prog_out),
        .raddr  (rd_addr),
        .rvalid (t_valid),
        .rnext  (t_next),
        .rout   (t_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_STATE;
            out_q   <= RESET_OUT;
            err_q   <= 1'b0;
        end else begin
            if (bus.err_clr) begin
                err_q <= 1'b0;
            end
            if (bus.en) begin
                if (t_valid) begin
                    state_q <= t_next;
                    out_q   <= t_out;
                end else begin
                    // Placed after the clear so a same-edge set wins.
                    state_q <= RESET_STATE;
                    out_q   <= RESET_OUT;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.state = state_q;
    assign bus.out   = out_q;
    assign bus.err   = err_q;

endmodule

// File: doc/table_fsm.md
Name: table_fsm

Overview:
- Parametrised, runtime-programmable table-driven Moore state machine; generalises the ROM-plus-flip-flop FSM style to configurable state, input and output widths.
- A transition table indexed by {in_sym, state} supplies the next state and its output.
- The table is loaded through a program port, so one instance can realise any FSM up to 2^STATE_W states.
- Entries carry a valid bit; an unprogrammed transition is detected and recovered from.

Parameters:
STATE_W, 3, state register width; 2^STATE_W states
IN_W, 1, input symbol width
OUT_W, 3, output width
RESET_STATE, 3'd2, state loaded on reset and on error recovery
RESET_OUT, 3'd0, output value loaded with RESET_STATE

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  advance one transition this cycle
in_sym  in  IN_W  input symbol, sampled when en=1
prog_we  in  1  write one table entry
prog_addr  in  STATE_W+IN_W  entry index; in_sym in MSBs, state in LSBs
prog_next  in  STATE_W  next-state field of the written entry
prog_out  in  OUT_W  output field of the written entry
err_clr  in  1  clears the sticky err flag
state  out  STATE_W  current state (registered)
out  out  OUT_W  current Moore output (registered)
err  out  1  sticky flag: an invalid entry was taken

Behaviour:
- Reset is asynchronous and active-low: reset=0 drives clk=don't-care.
  - state=RESET_STATE, out=RESET_OUT, err=0.
  - All table valid bits cleared; next/out table fields are not reset.
- Entry index addr = {in_sym, state}.
- Entry format: {valid, next[STATE_W], eout[OUT_W]}.
- Program write: on a rising edge with prog_we=1, entry[prog_addr] <= {1, prog_next, prog_out}. The entry is usable from the next cycle.
- Step, on a rising edge with en=1 and entry[addr].valid=1: state <= next, out <= eout. Latency is one clock from in_sym to state/out.
- Step on an invalid entry (en=1, valid=0): state <= RESET_STATE, out <= RESET_OUT, err <= 1.
- en=0: state, out and err hold; in_sym is ignored.
- Simultaneous prog_we and en with prog_addr == addr: the step uses the pre-write entry (read-before-write). The new entry applies from the following step.
- err_clr=1 clears err on the next edge. If err_clr and a new invalid step occur on the same edge, set wins and err=1.
- Out-of-range states cannot occur, since every STATE_W code is legal. Unprogrammed entries are covered by the valid bit.
- Reset asserted mid-sequence aborts immediately: outputs return to reset values and the whole program is invalidated.
- No combinational path from in_sym to out/state.
- Table is 2^(STATE_W+IN_W) entries (16 at defaults), implemented as flops so valid bits can be reset.

Decomposition:
- Shared package fsm_pkg holds:
  - entry field offsets and the entry-width expression (1+STATE_W+OUT_W);
  - an address-packing function {in_sym, state};
  - default RESET_STATE and RESET_OUT constants.
- One sub-module, fsm_table:
  - synchronous write port;
  - combinational read with read-before-write semantics;
  - per-entry valid bits cleared by reset.
- The top level keeps the state, out and err registers.

Test Plan:
1. Reset, then step without programming: reset=0 -> state=2, out=0, err=0; reset=1, en=1, in_sym=0 -> after 1 clk, state=2, out=0, err=1.
2. Program the 5-state machine, encodings E0=2, E3=1, E2=3, E4=4, E5=5 with outputs 0, 3, 2, 4, 5.
   - Entries: E0 -0-> E3, E0 -1-> E4, E3 -0-> E2, E3 -1-> E5, E4 -0-> E0, E4 -1-> E3, E2 -x-> E4, E5 -0-> E0, E5 -1-> E2.
   - Drive in_sym 0,1,1,0,0 with en=1 -> (state,out) = (1,3), (5,5), (3,2), (4,4), (2,0); err stays 0.
3. en=0 for 5 cycles with in_sym toggling -> state and out unchanged; then en=1, in_sym=1 from state 2 -> (4,4).
4. At state 1, rewrite entry addr {1,1} to next=3, out=2 with prog_we=1, en=1, in_sym=1 on the same edge -> old entry taken, state=5.
   - Return to state 1 and step with in_sym=1 -> state=3, out=2.
5. Force an invalid step (err=1), then err_clr=1 for 1 clk -> err=0.
   - Repeat the invalid step with err_clr=1 on the same edge -> err=1.
6. Assert reset asynchronously mid-sequence at state 5 -> state=2, out=0 immediately with no clock edge.
   - After release, any step -> err=1, confirming valid bits were cleared.
